adder_share_ctrl: RTL and testbench

Sequencing and arbitration controller that shares one combinational `adder32` between two independent requesters in the adder/ALU datapath. Each requester presents operands and carry-in over a valid/ready handshake. The block round-robin grants one request at a time, latches its operands, drives them into the shared adder, registers the sum and carry-out, and returns them on that requester's response channel. The adder instance itself lives outside this block, and this block drives its A/B/cin inputs.

---
 rtl/adder_ctrl_pkg.sv | 15 +
 rtl/rr_arb2.sv | 39 +++
 rtl/adder_share_ctrl.sv | 132 +++++++++++++
 tb/tb_adder_share_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the two-requester shared-adder controller.
package adder_ctrl_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arb2
  import adder_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       gid
);

  always_comb begin
    grant = '0;
    gid   = REQ0;
    case (valid)
      2'b01: begin
        grant = 2'b01;
        gid   = REQ0;
      end
      2'b10: begin
        grant = 2'b10;
        gid   = REQ1;
      end
      2'b11: begin
        if (last == REQ1) begin
          grant = 2'b01;
          gid   = REQ0;
        end else begin
          grant = 2'b10;
          gid   = REQ1;
        end
      end
      default: begin
        grant = '0;
        gid   = REQ0;
      end
    endcase
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Arbitrates two valid/ready requesters onto one external adder and returns
// the registered sum/carry on the granted requester's response channel.
module adder_share_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             busy,
  output logic [15:0]      ops_done
);

  state_t           state_q, state_d;
  logic             last_q;
  logic             id_q;
  logic [1:0]       grant;
  logic             gid;
  logic             accept;
  logic             rsp_hs;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             op_cin_q;
  logic [WIDTH-1:0] sum0_q, sum1_q;
  logic             cout0_q, cout1_q;
  logic [15:0]      ops_done_q;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .last  (last_q),
    .grant (grant),
    .gid   (gid)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rsp_hs  = 1'b0;
    case (state_q)
      IDLE: begin
        // The arbiter only grants a valid requester, so any grant is a handshake.
        if (|grant) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_hs = (id_q == REQ1) ? rsp1_ready : rsp0_ready;
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q     <= REQ1;
      id_q       <= REQ0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_cin_q   <= 1'b0;
      sum0_q     <= '0;
      sum1_q     <= '0;
      cout0_q    <= 1'b0;
      cout1_q    <= 1'b0;
      ops_done_q <= '0;
    end else begin
      if (accept) begin
        id_q     <= gid;
        op_a_q   <= (gid == REQ1) ? req1_a   : req0_a;
        op_b_q   <= (gid == REQ1) ? req1_b   : req0_b;
        op_cin_q <= (gid == REQ1) ? req1_cin : req0_cin;
      end
      if (state_q == EXEC) begin
        if (id_q == REQ1) begin
          sum1_q  <= add_s;
          cout1_q <= add_cout;
        end else begin
          sum0_q  <= add_s;
          cout0_q <= add_cout;
        end
      end
      if (rsp_hs) begin
        last_q     <= id_q;
        ops_done_q <= ops_done_q + 16'd1;
      end
    end
  end

  assign req0_ready = (state_q == IDLE) && grant[0];
  assign req1_ready = (state_q == IDLE) && grant[1];
  assign rsp0_valid = (state_q == RESP) && (id_q == REQ0);
  assign rsp1_valid = (state_q == RESP) && (id_q == REQ1);
  assign rsp0_sum   = sum0_q;
  assign rsp0_cout  = cout0_q;
  assign rsp1_sum   = sum1_q;
  assign rsp1_cout  = cout1_q;
  assign add_a      = op_a_q;
  assign add_b      = op_b_q;
  assign add_cin    = op_cin_q;
  assign busy       = (state_q != IDLE);
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: directed scenarios plus a randomized
// transaction-level scoreboard; the shared adder is modelled behind add_*.
module tb_adder_share_ctrl;
  import adder_ctrl_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp0_cout;
  logic         rsp1_valid, rsp1_ready, rsp1_cout;
  logic [W-1:0] rsp0_sum, rsp1_sum;
  logic [W-1:0] add_a, add_b, add_s;
  logic         add_cin, add_cout;
  logic         busy;
  logic [15:0]  ops_done;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_ops = '0;

  adder_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .busy(busy), .ops_done(ops_done)
  );

  // External shared adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  always #50 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_ops = '0;
    #1;
  endtask

  task automatic test_reset;
    apply_reset();
    step();
    vectors++;
    if ({add_a, add_b, add_cin} !== '0) begin
      miscompares++;
      $display("FAIL reset_adder_inputs: got a=%h b=%h cin=%b, expected all 0", add_a, add_b, add_cin);
    end
    vectors++;
    if ({rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout, busy, req0_ready, req1_ready} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got rv=%b%b cout=%b%b busy=%b rdy=%b%b, expected all 0",
               rsp1_valid, rsp0_valid, rsp1_cout, rsp0_cout, busy, req1_ready, req0_ready);
    end
    vectors++;
    if ({rsp0_sum, rsp1_sum, ops_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got sum0=%h sum1=%h ops=%h, expected 0", rsp0_sum, rsp1_sum, ops_done);
    end
  endtask

  task automatic test_single;
    req0_valid = 1'b1; req0_a = 32'h0000_0001; req0_b = 32'hFFFF_FFFF; req0_cin = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++; $display("FAIL single_ready: got %b, expected 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    #1;
    vectors++;
    if ({rsp0_valid, busy, add_a, add_b} !== {1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL single_exec: got rv=%b busy=%b a=%h b=%h, expected 0 1 00000001 ffffffff", rsp0_valid, busy, add_a, add_b);
    end
    step();
    vectors++;
    if ({rsp0_valid, rsp0_cout, rsp0_sum} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL single_resp: got v=%b cout=%b sum=%h, expected 1 1 00000000", rsp0_valid, rsp0_cout, rsp0_sum);
    end
    exp_ops++;
    step();
    vectors++;
    if ({rsp0_valid, busy, ops_done, rsp0_cout, rsp0_sum} !== {1'b0, 1'b0, 16'd1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL single_after: got v=%b busy=%b ops=%h cout=%b sum=%h, expected 0 0 0001 1 00000000",
               rsp0_valid, busy, ops_done, rsp0_cout, rsp0_sum);
    end
  endtask

  task automatic test_tie;
    apply_reset();
    step();
    req0_valid = 1'b1; req0_a = 32'd5;  req0_b = 32'd7;  req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_cin = 1'b1;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++; $display("FAIL tie_first_grant: got %b, expected 01", {req1_ready, req0_ready});
    end
    step();
    req0_valid = 1'b0;
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      miscompares++; $display("FAIL tie_exec_ready: got %b, expected 00", {req1_ready, req0_ready});
    end
    step();
    vectors++;
    if ({rsp0_valid, rsp1_valid, rsp0_cout, rsp0_sum} !== {1'b1, 1'b0, 1'b0, 32'd12}) begin
      miscompares++;
      $display("FAIL tie_rsp0: got v0=%b v1=%b cout=%b sum=%h, expected 1 0 0 0000000c", rsp0_valid, rsp1_valid, rsp0_cout, rsp0_sum);
    end
    exp_ops++;
    step();
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      miscompares++; $display("FAIL tie_second_grant: got %b, expected 10", {req1_ready, req0_ready});
    end
    step();
    req1_valid = 1'b0;
    step();
    vectors++;
    if ({rsp1_valid, rsp0_valid, rsp1_cout, rsp1_sum} !== {1'b1, 1'b0, 1'b0, 32'd31}) begin
      miscompares++;
      $display("FAIL tie_rsp1: got v1=%b v0=%b cout=%b sum=%h, expected 1 0 0 0000001f", rsp1_valid, rsp0_valid, rsp1_cout, rsp1_sum);
    end
    exp_ops++;
    step();
  endtask

  task automatic test_fairness;
    logic [W:0] q0[$];
    logic [W:0] q1[$];
    int ngrant = 0;
    int ndone = 0;
    bit renew0 = 1'b0;
    bit renew1 = 1'b0;
    apply_reset();
    step();
    req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1));
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1));
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && ndone < 6; cyc++) begin
      if (renew0) begin req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1)); renew0 = 1'b0; end
      if (renew1) begin req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1)); renew1 = 1'b0; end
      if (ngrant >= 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (rsp0_valid) begin
        vectors++;
        if (q0.size() == 0 || {rsp0_cout, rsp0_sum} !== q0[0]) begin
          miscompares++; $display("FAIL fair_rsp0: got %h, expected %h (queued %0d)", {rsp0_cout, rsp0_sum}, (q0.size() != 0) ? q0[0] : '0, q0.size());
        end
        if (q0.size() != 0) void'(q0.pop_front());
        ndone++; exp_ops++;
      end
      if (rsp1_valid) begin
        vectors++;
        if (q1.size() == 0 || {rsp1_cout, rsp1_sum} !== q1[0]) begin
          miscompares++; $display("FAIL fair_rsp1: got %h, expected %h (queued %0d)", {rsp1_cout, rsp1_sum}, (q1.size() != 0) ? q1[0] : '0, q1.size());
        end
        if (q1.size() != 0) void'(q1.pop_front());
        ndone++; exp_ops++;
      end
      if (req0_ready || req1_ready) begin
        vectors++;
        if ({req1_ready, req0_ready} !== ((ngrant % 2 == 0) ? 2'b01 : 2'b10)) begin
          miscompares++;
          $display("FAIL fair_grant: got %b at grant %0d, expected %b", {req1_ready, req0_ready}, ngrant, (ngrant % 2 == 0) ? 2'b01 : 2'b10);
        end
        if (req1_ready) begin q1.push_back(ref_add(req1_a, req1_b, req1_cin)); renew1 = 1'b1; end
        else            begin q0.push_back(ref_add(req0_a, req0_b, req0_cin)); renew0 = 1'b1; end
        ngrant++;
      end
      step();
    end
    vectors++;
    if (ndone != 6 || ops_done !== exp_ops || exp_ops !== 16'd6) begin
      miscompares++; $display("FAIL fair_count: got %0d responses ops_done=%0d, expected 6 and 6", ndone, ops_done);
    end
  endtask

  task automatic test_backpressure;
    logic [W:0]  e;
    logic [36:0] want;
    req0_valid = 1'b0; req1_valid = 1'b1;
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1));
    rsp1_ready = 1'b0;
    e = ref_add(req1_a, req1_b, req1_cin);
    want = {1'b1, e[W], e[W-1:0], 3'b001};
    #1;
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_accept: got %b, expected 1", req1_ready);
    end
    step();
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom;
    req1_a = $urandom; req1_b = $urandom;
    step();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({rsp1_valid, rsp1_cout, rsp1_sum, req1_ready, req0_ready, busy} !== want) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got v=%b cout=%b sum=%h rdy=%b%b busy=%b, expected %h",
                 i, rsp1_valid, rsp1_cout, rsp1_sum, req1_ready, req0_ready, busy, want);
      end
      if (i < 5) step();
    end
    rsp1_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    exp_ops++;
    step();
    vectors++;
    if ({rsp1_valid, busy, ops_done, rsp1_cout, rsp1_sum} !== {1'b0, 1'b0, exp_ops, e}) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b busy=%b ops=%h cout=%b sum=%h, expected 0 0 %h %h",
               rsp1_valid, busy, ops_done, rsp1_cout, rsp1_sum, exp_ops, e);
    end
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_cin = 1'b1;
    step();
    req0_valid = 1'b0;
    resetn = 1'b0;
    #1;
    exp_ops = '0;
    vectors++;
    if ({rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout, add_cin, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL rstmid_flags: got rv=%b%b cout=%b%b cin=%b busy=%b, expected all 0",
               rsp1_valid, rsp0_valid, rsp1_cout, rsp0_cout, add_cin, busy);
    end
    vectors++;
    if ({rsp0_sum, rsp1_sum, add_a, add_b, ops_done} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_regs: got s0=%h s1=%h a=%h b=%h ops=%h, expected 0", rsp0_sum, rsp1_sum, add_a, add_b, ops_done);
    end
    step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_no_rsp: got activity=%b after reset, expected 0", seen);
    end
    req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'h8000_0000; req1_cin = 1'b0;
    #1;
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_accept: got %b, expected 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    step();
    vectors++;
    if ({rsp1_valid, rsp1_cout, rsp1_sum} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL rstmid_rsp1: got v=%b cout=%b sum=%h, expected 1 1 00000000", rsp1_valid, rsp1_cout, rsp1_sum);
    end
    exp_ops++;
    step();
    vectors++;
    if (ops_done !== 16'd1) begin
      miscompares++; $display("FAIL rstmid_ops: got %h, expected 0001", ops_done);
    end
  endtask

  // Transaction-level model: one outstanding op, response visible two cycles
  // after acceptance, round-robin against the last requester served.
  task automatic test_random;
    bit         out = 1'b0;
    bit         out_id = 1'b0;
    bit         last_srv = 1'b1;
    int         age = 0;
    logic [W:0] out_exp = '0;
    logic [1:0] exp_rv, exp_rdy;
    apply_reset();
    step();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = ($urandom_range(0, 9) < 6); req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(0, 1));
      req1_valid = ($urandom_range(0, 9) < 6); req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(0, 1));
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rv = (out && age >= 2) ? (out_id ? 2'b10 : 2'b01) : 2'b00;
      vectors++;
      if ({rsp1_valid, rsp0_valid} !== exp_rv) begin
        miscompares++; $display("FAIL rand_rsp_valid: cycle %0d got %b, expected %b", cyc, {rsp1_valid, rsp0_valid}, exp_rv);
      end
      if (exp_rv != 2'b00) begin
        vectors++;
        if ((out_id ? {rsp1_cout, rsp1_sum} : {rsp0_cout, rsp0_sum}) !== out_exp) begin
          miscompares++;
          $display("FAIL rand_rsp_data: cycle %0d got %h, expected %h", cyc, out_id ? {rsp1_cout, rsp1_sum} : {rsp0_cout, rsp0_sum}, out_exp);
        end
      end
      if (out) exp_rdy = 2'b00;
      else if (req0_valid && req1_valid) exp_rdy = last_srv ? 2'b01 : 2'b10;
      else exp_rdy = {req1_valid, req0_valid};
      vectors++;
      if ({req1_ready, req0_ready, busy, ops_done} !== {exp_rdy, out, exp_ops}) begin
        miscompares++;
        $display("FAIL rand_ctrl: cycle %0d got rdy=%b busy=%b ops=%h, expected rdy=%b busy=%b ops=%h",
                 cyc, {req1_ready, req0_ready}, busy, ops_done, exp_rdy, out, exp_ops);
      end
      if (out && age >= 2 && (out_id ? rsp1_ready : rsp0_ready)) begin
        out = 1'b0; last_srv = out_id; exp_ops++;
      end else if (exp_rdy != 2'b00) begin
        out = 1'b1; age = 0; out_id = exp_rdy[1];
        out_exp = exp_rdy[1] ? ref_add(req1_a, req1_b, req1_cin) : ref_add(req0_a, req0_b, req0_cin);
      end
      if (out) age++;
      step();
    end
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_wrap;
    apply_reset();
    step();
    force dut.ops_done_q = 16'hFFFF;
    #1;
    release dut.ops_done_q;
    exp_ops = 16'hFFFF;
    #1;
    vectors++;
    if (ops_done !== exp_ops) begin
      miscompares++; $display("FAIL wrap_preload: got %h, expected ffff", ops_done);
    end
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_cin = 1'b0;
    rsp0_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    exp_ops++;
    step();
    vectors++;
    if (ops_done !== 16'h0000 || exp_ops !== 16'h0000) begin
      miscompares++; $display("FAIL wrap_rollover: got %h, expected 0000", ops_done);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
